min_tx_scheduler: RTL and testbench



---
 rtl/min_pkg.sv | 19 +
 rtl/crc32_byte.sv | 18 +
 rtl/min_tx_scheduler.sv | 162 ++++++++++++++++
 tb/tb_min_tx_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/min_pkg.sv
// rtl/min_pkg.sv - shared MIN framing constants, CRC32 constants and scheduler states
package min_pkg;

    localparam logic [7:0]  MIN_SOF    = 8'hAA;
    localparam logic [7:0]  MIN_EOF    = 8'h55;

    localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LATCH     = 3'd1,
        S_CRC       = 3'd2,
        S_START     = 3'd3,
        S_WAIT_BUSY = 3'd4,
        S_WAIT_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/crc32_byte.sv
// rtl/crc32_byte.sv - one byte of reflected CRC-32, purely combinational
module crc32_byte
    import min_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] next_crc
);

    // Eight LSB-first shift/xor steps on the running CRC
    always_comb begin
        next_crc = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            next_crc = next_crc[0] ? ((next_crc >> 1) ^ CRC32_POLY) : (next_crc >> 1);
        end
    end

endmodule

// File: rtl/min_tx_scheduler.sv
// rtl/min_tx_scheduler.sv - round-robin sharing of the MIN transmitter between channels
module min_tx_scheduler
    import min_pkg::*;
#(
    parameter int         N_CH        = 4,
    parameter int         N_DATA_BYTE = 4,
    parameter logic [7:0] ID_BASE     = 8'h10,
    parameter int         TX_TIMEOUT  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [N_CH-1:0]               i_req,
    input  logic [N_CH*N_DATA_BYTE*8-1:0] i_data,
    input  logic                          i_tx_busy,
    output logic [N_CH-1:0]               o_ack,
    output logic                          o_tx_en,
    output logic [7:0]                    o_id,
    output logic [N_DATA_BYTE*8-1:0]      o_data,
    output logic [31:0]                   o_crc32,
    output logic                          o_busy,
    output logic                          o_err
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DW    = N_DATA_BYTE * 8;
    localparam int BI_W  = $clog2(N_DATA_BYTE + 2);
    localparam int CNT_W = $clog2(TX_TIMEOUT + 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] sel_hi;
    logic [IDX_W-1:0] sel_lo;
    logic             found;
    logic             found_hi;
    logic [DW-1:0]    sel_data;
    logic [31:0]      crc;
    logic [31:0]      crc_next;
    logic [7:0]       crc_byte;
    logic [BI_W-1:0]  bidx;
    logic [CNT_W-1:0] cnt;

    // Round-robin pick: lowest requester at or above the pointer, else lowest overall
    always_comb begin
        found_hi = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                sel_lo = IDX_W'(k);
                if (IDX_W'(k) >= ptr) begin
                    found_hi = 1'b1;
                    sel_hi   = IDX_W'(k);
                end
            end
        end
        found = |i_req;
        sel   = found_hi ? sel_hi : sel_lo;
    end

    // Payload of the granted channel and the byte fed to the CRC this cycle
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == IDX_W'(k)) sel_data = i_data[k*DW +: DW];
        end
        crc_byte = 8'h00;
        if (bidx == BI_W'(0)) begin
            crc_byte = o_id;
        end else if (bidx == BI_W'(1)) begin
            crc_byte = 8'(N_DATA_BYTE);
        end else begin
            for (int p = 0; p < N_DATA_BYTE; p++) begin
                if (bidx == BI_W'(p + 2)) crc_byte = o_data[(N_DATA_BYTE-1-p)*8 +: 8];
            end
        end
    end

    crc32_byte u_crc32_byte (
        .crc      (crc),
        .data     (crc_byte),
        .next_crc (crc_next)
    );

    // Frame sequencer: grant, latch, byte-serial CRC, start pulse, transmitter handshake
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            idx     <= '0;
            crc     <= CRC32_INIT;
            bidx    <= '0;
            cnt     <= '0;
            o_ack   <= '0;
            o_tx_en <= 1'b0;
            o_id    <= '0;
            o_data  <= '0;
            o_crc32 <= '0;
            o_busy  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_ack   <= '0;
            o_tx_en <= 1'b0;
            o_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        idx    <= sel;
                        o_ack  <= N_CH'(1) << sel;
                        o_busy <= 1'b1;
                        state  <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    o_data <= sel_data;
                    o_id   <= ID_BASE + 8'(idx);
                    ptr    <= (idx == IDX_W'(N_CH - 1)) ? '0 : idx + IDX_W'(1);
                    crc    <= CRC32_INIT;
                    bidx   <= '0;
                    state  <= S_CRC;
                end
                S_CRC: begin
                    crc  <= crc_next;
                    bidx <= bidx + BI_W'(1);
                    if (bidx == BI_W'(N_DATA_BYTE + 1)) begin
                        o_crc32 <= ~crc_next;
                        o_tx_en <= 1'b1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (cnt == CNT_W'(TX_TIMEOUT - 2)) begin
                        // Abort lands the o_err pulse TX_TIMEOUT cycles after o_tx_en
                        o_err  <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_min_tx_scheduler.sv
// tb/tb_min_tx_scheduler.sv - directed self-checking bench for min_tx_scheduler
module tb_min_tx_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] data;
    logic         tx_busy;
    logic [3:0]   ack;
    logic         tx_en;
    logic [7:0]   id;
    logic [31:0]  odata;
    logic [31:0]  crc32;
    logic         busy;
    logic         err;

    logic [31:0]  u_crc_in;
    logic [7:0]   u_byte;
    logic [31:0]  u_crc_out;

    logic         tx_model_on = 1'b0;
    int           tx_t = -1;
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    min_tx_scheduler #(
        .N_CH        (4),
        .N_DATA_BYTE (4),
        .ID_BASE     (8'h10),
        .TX_TIMEOUT  (16)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_data    (data),
        .i_tx_busy (tx_busy),
        .o_ack     (ack),
        .o_tx_en   (tx_en),
        .o_id      (id),
        .o_data    (odata),
        .o_crc32   (crc32),
        .o_busy    (busy),
        .o_err     (err)
    );

    crc32_byte u_crc_unit (
        .crc      (u_crc_in),
        .data     (u_byte),
        .next_crc (u_crc_out)
    );

    // Transmitter model: busy rises 2 cycles after o_tx_en and stays up for 20 cycles
    always @(negedge clk) begin
        if (tx_en) tx_t = 0;
        else if (tx_t >= 0) tx_t++;
        tx_busy = tx_model_on && (tx_t >= 2) && (tx_t < 22);
    end

    function automatic logic [31:0] crc_frame(input logic [7:0] fid, input logic [31:0] pl);
        logic [31:0] c;
        logic [7:0]  b [6];
        b[0] = fid;
        b[1] = 8'd4;
        b[2] = pl[31:24];
        b[3] = pl[23:16];
        b[4] = pl[15:8];
        b[5] = pl[7:0];
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 6; i++) begin
            c ^= {24'h000000, b[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 200; i++) begin
            tick();
            if (busy === 1'b0) break;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle_wait: busy=%b after %0d cycles, required 0", name, busy, i);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = 4'b0000;
        repeat (3) tick();
        tests++;
        if (ack !== 4'b0000 || tx_en !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_pulses: ack=%b tx_en=%b err=%b, required 0", ack, tx_en, err);
        end
        tests++;
        if (id !== 8'h00 || odata !== 32'h0 || crc32 !== 32'h0) begin
            fails++;
            $display("FAIL reset_regs: id=%h data=%h crc=%h, required 0", id, odata, crc32);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got %b required 0", busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_crc_unit;
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) begin
            u_crc_in = c;
            u_byte   = 8'h31 + 8'(i);
            #1;
            c = u_crc_out;
        end
        tests++;
        if (~c !== 32'hCBF43926) begin
            fails++;
            $display("FAIL crc_unit_check: got %h required cbf43926", ~c);
        end
    endtask

    task automatic test_contention;
        logic [3:0] exp_order [5];
        int g;
        exp_order[0] = 4'b0001;
        exp_order[1] = 4'b0010;
        exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000;
        exp_order[4] = 4'b0001;
        tx_model_on = 1'b1;
        req = 4'b1111;
        g = 0;
        for (int c = 0; c < 400 && g < 5; c++) begin
            tick();
            if (ack !== 4'b0000) begin
                tests++;
                if (ack !== exp_order[g]) begin
                    fails++;
                    $display("FAIL contention_grant%0d: got %b required %b", g, ack, exp_order[g]);
                end
                g++;
            end
        end
        req = 4'b0000;
        tests++;
        if (g != 5) begin
            fails++;
            $display("FAIL contention_count: got %0d grants required 5", g);
        end
        wait_idle("contention");
    endtask

    task automatic test_single;
        int n;
        data[95:64] = 32'hDEADBEEF;
        req = 4'b0100;
        tick();
        tests++;
        if (ack !== 4'b0100) begin
            fails++;
            $display("FAIL single_ack: got %b required 0100", ack);
        end
        req = 4'b0000;
        tick();
        tests++;
        if (ack !== 4'b0000) begin
            fails++;
            $display("FAIL single_ack_pulse: got %b required 0000", ack);
        end
        n = 2;
        while (tx_en !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (n != 8) begin
            fails++;
            $display("FAIL single_latency: tx_en after %0d cycles required 8", n);
        end
        tests++;
        if (id !== 8'h12 || odata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL single_latch: id=%h data=%h required 12 deadbeef", id, odata);
        end
        tests++;
        if (crc32 !== crc_frame(8'h12, 32'hDEADBEEF)) begin
            fails++;
            $display("FAIL single_crc: got %h required %h", crc32, crc_frame(8'h12, 32'hDEADBEEF));
        end
        wait_idle("single");
    endtask

    task automatic test_handshake;
        logic [7:0]  sid;
        logic [31:0] sdata;
        logic [31:0] scrc;
        int n;
        int gap;
        int busy_bad;
        int stable_bad;
        data[63:32] = 32'h01020304;
        req = 4'b0010;
        n = 0;
        while (tx_en !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        sid   = id;
        sdata = odata;
        scrc  = crc32;
        tests++;
        if (sdata !== 32'h01020304 || scrc !== crc_frame(8'h11, 32'h01020304)) begin
            fails++;
            $display("FAIL hs_first_frame: data=%h crc=%h required 01020304 %h",
                     sdata, scrc, crc_frame(8'h11, 32'h01020304));
        end
        data[63:32] = 32'hCAFEF00D;
        gap = 0;
        busy_bad = 0;
        stable_bad = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k <= 22 && busy !== 1'b1) busy_bad++;
            if (k == 23 && busy !== 1'b0) busy_bad++;
            if (k <= 22 && (id !== sid || odata !== sdata || crc32 !== scrc)) stable_bad++;
            if (tx_en === 1'b1) begin
                gap = k;
                break;
            end
        end
        req = 4'b0000;
        tests++;
        if (busy_bad != 0) begin
            fails++;
            $display("FAIL hs_busy_hold: %0d bad cycles required 0", busy_bad);
        end
        tests++;
        if (stable_bad != 0) begin
            fails++;
            $display("FAIL hs_outputs_stable: %0d bad cycles required 0", stable_bad);
        end
        tests++;
        if (gap != 31) begin
            fails++;
            $display("FAIL hs_tx_en_gap: got %0d cycles required 31", gap);
        end
        tests++;
        if (id !== 8'h11 || odata !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL hs_second_frame: id=%h data=%h required 11 cafef00d", id, odata);
        end
        wait_idle("handshake");
    endtask

    task automatic test_timeout;
        int n;
        int k;
        tx_model_on = 1'b0;
        tick();
        data[31:0] = 32'h11223344;
        req = 4'b0001;
        tick();
        req = 4'b0000;
        n = 0;
        while (tx_en !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        for (k = 1; k <= 40; k++) begin
            tick();
            if (err === 1'b1) break;
        end
        tests++;
        if (k != 16) begin
            fails++;
            $display("FAIL timeout_delay: err after %0d cycles required 16", k);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_idle: busy=%b required 0", busy);
        end
        req = 4'b0011;
        tick();
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL timeout_err_pulse: err=%b required 0", err);
        end
        tests++;
        if (ack !== 4'b0010) begin
            fails++;
            $display("FAIL timeout_ptr_advance: ack=%b required 0010", ack);
        end
        req = 4'b0000;
        wait_idle("timeout");
    endtask

    task automatic test_reset_mid;
        int n;
        data[127:96] = 32'h55667788;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        repeat (2) tick();
        tests++;
        if (busy !== 1'b1 || id !== 8'h12) begin
            fails++;
            $display("FAIL rstmid_in_crc: busy=%b id=%h required 1 12", busy, id);
        end
        rst = 1'b1;
        tick();
        tests++;
        if (busy !== 1'b0 || ack !== 4'b0000 || tx_en !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_ctrl: busy=%b ack=%b tx_en=%b err=%b required 0",
                     busy, ack, tx_en, err);
        end
        tests++;
        if (id !== 8'h00 || odata !== 32'h0 || crc32 !== 32'h0) begin
            fails++;
            $display("FAIL rstmid_regs: id=%h data=%h crc=%h required 0", id, odata, crc32);
        end
        rst = 1'b0;
        req = 4'b1001;
        tick();
        tests++;
        if (ack !== 4'b0001) begin
            fails++;
            $display("FAIL rstmid_ptr_zero: ack=%b required 0001", ack);
        end
        req = 4'b0000;
        n = 1;
        while (tx_en !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (n != 8 || id !== 8'h10 || crc32 !== crc_frame(8'h10, 32'h11223344)) begin
            fails++;
            $display("FAIL rstmid_regrant: latency=%0d id=%h crc=%h required 8 10 %h",
                     n, id, crc32, crc_frame(8'h10, 32'h11223344));
        end
        wait_idle("rstmid");
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        data = {32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        u_crc_in = 32'h0;
        u_byte   = 8'h00;
        test_reset();
        test_crc_unit();
        test_contention();
        test_single();
        test_handshake();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
